// File: rtl/input_spike_scheduler.sv
// input_spike_scheduler
//   Per-timestep controller for the input spike FIFO. It shares the single
//   FIFO port between the external loader (enqueue, IDLE only) and the
//   timestep dispatcher (dequeue). On Start it drains every queued event whose
//   time is at or below the latched network time, hands each one to the
//   router over valid/ready, and then pulses StepDone.
//
// Ports
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   Start, CurrentBT    timestep request and network time (latched on Start)
//   ExtValid/ExtBT/ExtNID/ExtReady   loader event interface
//   FIFO_*              strobes and data to/from the input FIFO
//   SpikeValid/SpikeNID/SpikeBT/SpikeReady   router handshake
//   StepDone            one-cycle end-of-step pulse
//   SpikeCount          spikes dispatched in the current or last step
//   Busy                high in every state except IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SETTLE   | one cycle after reset so the FIFO empty flag is valid
// IDLE     | loader may enqueue; waits for Start
// CHECK    | compare FIFO head time against the latched step time
// POP      | single-cycle dequeue strobe
// CAPTURE  | FIFO output registers valid; copy into the spike registers
// OFFER    | spike held on the router interface until SpikeReady
// DONE     | StepDone pulse, then back to IDLE
module input_spike_scheduler #(
  parameter int BT_WIDTH     = 36,
  parameter int NEURON_WIDTH = 11,
  parameter int COUNT_WIDTH  = 12
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [BT_WIDTH-1:0]     CurrentBT,
  input  logic                    ExtValid,
  input  logic [BT_WIDTH-1:0]     ExtBT,
  input  logic [NEURON_WIDTH-1:0] ExtNID,
  output logic                    ExtReady,
  output logic                    FIFO_QueueEnable,
  output logic                    FIFO_Enqueue,
  output logic                    FIFO_Dequeue,
  output logic [BT_WIDTH-1:0]     FIFO_BTIn,
  output logic [NEURON_WIDTH-1:0] FIFO_NIDIn,
  input  logic [BT_WIDTH-1:0]     FIFO_BTOut,
  input  logic [NEURON_WIDTH-1:0] FIFO_NIDOut,
  input  logic [BT_WIDTH-1:0]     FIFO_BT_Head,
  input  logic                    FIFO_IsQueueEmpty,
  input  logic                    FIFO_IsQueueFull,
  output logic                    SpikeValid,
  output logic [NEURON_WIDTH-1:0] SpikeNID,
  output logic [BT_WIDTH-1:0]     SpikeBT,
  input  logic                    SpikeReady,
  output logic                    StepDone,
  output logic [COUNT_WIDTH-1:0]  SpikeCount,
  output logic                    Busy
);

  typedef enum logic [2:0] {
    S_SETTLE,
    S_IDLE,
    S_CHECK,
    S_POP,
    S_CAPTURE,
    S_OFFER,
    S_DONE
  } state_t;

  state_t              state;
  logic [BT_WIDTH-1:0] step_bt;
  logic                enq;
  logic                deq;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_SETTLE;
      step_bt    <= '0;
      SpikeValid <= 1'b0;
      SpikeNID   <= '0;
      SpikeBT    <= '0;
      SpikeCount <= '0;
    end else begin
      case (state)
        S_SETTLE: state <= S_IDLE;
        S_IDLE: begin
          if (Start) begin
            step_bt    <= CurrentBT;
            SpikeCount <= '0;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Late arrivals (head below step time) and equality both dispatch.
          if (FIFO_IsQueueEmpty || (FIFO_BT_Head > step_bt))
            state <= S_DONE;
          else
            state <= S_POP;
        end
        S_POP: state <= S_CAPTURE;
        S_CAPTURE: begin
          SpikeBT    <= FIFO_BTOut;
          SpikeNID   <= FIFO_NIDOut;
          SpikeValid <= 1'b1;
          state      <= S_OFFER;
        end
        S_OFFER: begin
          if (SpikeReady) begin
            SpikeValid <= 1'b0;
            if (SpikeCount != {COUNT_WIDTH{1'b1}})
              SpikeCount <= SpikeCount + COUNT_WIDTH'(1);
            state <= S_CHECK;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_SETTLE;
      endcase
    end
  end

  // Start takes priority over the loader in IDLE; the loader simply holds.
  assign ExtReady         = (state == S_IDLE) && !FIFO_IsQueueFull && !Start;
  assign enq              = ExtValid && ExtReady;
  assign deq              = (state == S_POP);

  assign FIFO_Enqueue     = enq;
  assign FIFO_Dequeue     = deq;
  assign FIFO_QueueEnable = enq || deq;
  assign FIFO_BTIn        = enq ? ExtBT  : '0;
  assign FIFO_NIDIn       = enq ? ExtNID : '0;

  assign StepDone         = (state == S_DONE);
  assign Busy             = (state != S_IDLE);

endmodule

// File: tb/tb_input_spike_scheduler.sv
module tb_input_spike_scheduler;
  localparam int BTW   = 36;
  localparam int NW    = 11;
  localparam int CW    = 12;
  localparam int DEPTH = 2048;

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic           Start = 1'b0;
  logic [BTW-1:0] CurrentBT = '0;
  logic           ExtValid = 1'b0;
  logic [BTW-1:0] ExtBT = '0;
  logic [NW-1:0]  ExtNID = '0;
  logic           SpikeReady = 1'b0;

  logic           ExtReady, FIFO_QueueEnable, FIFO_Enqueue, FIFO_Dequeue;
  logic [BTW-1:0] FIFO_BTIn, FIFO_BT_Head, SpikeBT;
  logic [NW-1:0]  FIFO_NIDIn, SpikeNID;
  logic           FIFO_IsQueueEmpty, FIFO_IsQueueFull;
  logic           SpikeValid, StepDone, Busy;
  logic [CW-1:0]  SpikeCount;
  logic [BTW-1:0] FIFO_BTOut = '0;
  logic [NW-1:0]  FIFO_NIDOut = '0;

  int errors = 0;
  int checks = 0;
  int enq_cnt = 0, deq_cnt = 0, done_cnt = 0, both_cnt = 0, qe_bad = 0;

  always #5 Clock = ~Clock;

  input_spike_scheduler #(.BT_WIDTH(BTW), .NEURON_WIDTH(NW), .COUNT_WIDTH(CW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .CurrentBT(CurrentBT),
    .ExtValid(ExtValid), .ExtBT(ExtBT), .ExtNID(ExtNID), .ExtReady(ExtReady),
    .FIFO_QueueEnable(FIFO_QueueEnable), .FIFO_Enqueue(FIFO_Enqueue),
    .FIFO_Dequeue(FIFO_Dequeue), .FIFO_BTIn(FIFO_BTIn), .FIFO_NIDIn(FIFO_NIDIn),
    .FIFO_BTOut(FIFO_BTOut), .FIFO_NIDOut(FIFO_NIDOut), .FIFO_BT_Head(FIFO_BT_Head),
    .FIFO_IsQueueEmpty(FIFO_IsQueueEmpty), .FIFO_IsQueueFull(FIFO_IsQueueFull),
    .SpikeValid(SpikeValid), .SpikeNID(SpikeNID), .SpikeBT(SpikeBT),
    .SpikeReady(SpikeReady), .StepDone(StepDone), .SpikeCount(SpikeCount), .Busy(Busy)
  );

  // Behavioural single-port FIFO: registered outputs, combinational head.
  logic [BTW-1:0] fbt  [DEPTH];
  logic [NW-1:0]  fnid [DEPTH];
  logic [10:0]    rd_ptr = '0, wr_ptr = '0;
  int             fcount = 0;

  assign FIFO_BT_Head      = fbt[rd_ptr];
  assign FIFO_IsQueueEmpty = (fcount == 0);
  assign FIFO_IsQueueFull  = (fcount == DEPTH);

  always @(posedge Clock) begin
    int inc, dec;
    inc = 0; dec = 0;
    if (FIFO_QueueEnable && FIFO_Enqueue && fcount < DEPTH) begin
      fbt[wr_ptr]  <= FIFO_BTIn;
      fnid[wr_ptr] <= FIFO_NIDIn;
      wr_ptr       <= wr_ptr + 11'd1;
      inc = 1;
    end
    if (FIFO_QueueEnable && FIFO_Dequeue && fcount > 0) begin
      FIFO_BTOut  <= fbt[rd_ptr];
      FIFO_NIDOut <= fnid[rd_ptr];
      rd_ptr      <= rd_ptr + 11'd1;
      dec = 1;
    end
    fcount <= fcount + inc - dec;
  end

  always @(posedge Clock) begin
    if (FIFO_QueueEnable && FIFO_Enqueue) enq_cnt++;
    if (FIFO_QueueEnable && FIFO_Dequeue) deq_cnt++;
    if (StepDone) done_cnt++;
    if (FIFO_Enqueue && FIFO_Dequeue) both_cnt++;
    if (FIFO_QueueEnable != (FIFO_Enqueue || FIFO_Dequeue)) qe_bad++;
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [BTW-1:0] bt, input logic [NW-1:0] nid);
    ExtBT = bt; ExtNID = nid; ExtValid = 1'b1;
    tick;
    ExtValid = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick; tick;
    checks++; if (SpikeValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", SpikeValid); end
    checks++; if (SpikeCount !== 12'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", SpikeCount); end
    checks++; if (StepDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", StepDone); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL reset_busy_settle: got %0b expected 1", Busy); end
    checks++; if (ExtReady !== 1'b0) begin errors++; $display("FAIL reset_extready: got %0b expected 0", ExtReady); end
    Reset = 1'b0;
    tick;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", Busy); end
    checks++; if (ExtReady !== 1'b1) begin errors++; $display("FAIL idle_extready: got %0b expected 1", ExtReady); end
  endtask

  task automatic test_empty_step;
    int d0;
    d0 = deq_cnt;
    CurrentBT = '0; Start = 1'b1;
    tick; Start = 1'b0;
    checks++; if (StepDone !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL empty_cycle1: got done=%0b busy=%0b expected done=0 busy=1", StepDone, Busy); end
    tick;
    checks++; if (StepDone !== 1'b1) begin errors++; $display("FAIL empty_done_latency: got %0b expected 1", StepDone); end
    checks++; if (SpikeCount !== 12'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", SpikeCount); end
    tick;
    checks++; if (StepDone !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL empty_back_idle: got done=%0b busy=%0b expected 0 0", StepDone, Busy); end
    checks++; if (deq_cnt !== d0) begin errors++; $display("FAIL empty_no_dequeue: got %0d expected %0d", deq_cnt, d0); end
  endtask

  task automatic test_dispatch;
    logic [NW-1:0]  nids [4];
    logic [BTW-1:0] bts  [4];
    int times [4];
    int n, done_at, d0;
    n = 0; done_at = -1;
    ExtBT = 36'd16; ExtNID = 11'd3; ExtValid = 1'b1;
    #1;
    checks++; if (ExtReady !== 1'b1 || FIFO_Enqueue !== 1'b1 || FIFO_QueueEnable !== 1'b1)
      begin errors++; $display("FAIL load_strobes: got rdy=%0b enq=%0b qe=%0b expected 1 1 1", ExtReady, FIFO_Enqueue, FIFO_QueueEnable); end
    checks++; if (FIFO_BTIn !== 36'd16 || FIFO_NIDIn !== 11'd3)
      begin errors++; $display("FAIL load_data: got bt=%0d nid=%0d expected 16 3", FIFO_BTIn, FIFO_NIDIn); end
    tick; ExtValid = 1'b0;
    load(36'd16, 11'd7);
    load(36'd32, 11'd1);
    d0 = deq_cnt;
    SpikeReady = 1'b1; CurrentBT = 36'd16; Start = 1'b1;
    for (int i = 1; i <= 40 && done_at < 0; i++) begin
      tick; Start = 1'b0;
      if (SpikeValid && n < 4) begin nids[n] = SpikeNID; bts[n] = SpikeBT; times[n] = i; n++; end
      if (StepDone) done_at = i;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL dispatch_num: got %0d expected 2", n); end
    if (n >= 2) begin
      checks++; if (nids[0] !== 11'd3 || nids[1] !== 11'd7) begin errors++; $display("FAIL dispatch_nids: got %0d,%0d expected 3,7", nids[0], nids[1]); end
      checks++; if (bts[0] !== 36'd16 || bts[1] !== 36'd16) begin errors++; $display("FAIL dispatch_bts: got %0d,%0d expected 16,16", bts[0], bts[1]); end
      checks++; if (times[0] !== 4 || times[1] !== 8) begin errors++; $display("FAIL dispatch_latency: got %0d,%0d expected 4,8", times[0], times[1]); end
    end
    checks++; if (done_at !== 10) begin errors++; $display("FAIL dispatch_done_at: got %0d expected 10", done_at); end
    checks++; if (SpikeCount !== 12'd2) begin errors++; $display("FAIL dispatch_count: got %0d expected 2", SpikeCount); end
    checks++; if (FIFO_IsQueueEmpty !== 1'b0 || FIFO_BT_Head !== 36'd32) begin errors++; $display("FAIL dispatch_remaining_head: got empty=%0b head=%0d expected 0 32", FIFO_IsQueueEmpty, FIFO_BT_Head); end
    checks++; if (deq_cnt - d0 !== 2) begin errors++; $display("FAIL dispatch_dequeues: got %0d expected 2", deq_cnt - d0); end
    tick;
  endtask

  task automatic test_drain;
    logic [NW-1:0]  nid0;
    logic [BTW-1:0] bt0;
    int n, done_at;
    n = 0; done_at = -1; nid0 = '0; bt0 = '0;
    CurrentBT = 36'd32; Start = 1'b1;
    for (int i = 1; i <= 30 && done_at < 0; i++) begin
      tick; Start = 1'b0;
      if (SpikeValid) begin if (n == 0) begin nid0 = SpikeNID; bt0 = SpikeBT; end n++; end
      if (StepDone) done_at = i;
    end
    checks++; if (n !== 1 || nid0 !== 11'd1 || bt0 !== 36'd32) begin errors++; $display("FAIL drain_spike: got n=%0d nid=%0d bt=%0d expected 1 1 32", n, nid0, bt0); end
    checks++; if (done_at < 0) begin errors++; $display("FAIL drain_done: got none expected StepDone"); end
    checks++; if (SpikeCount !== 12'd1) begin errors++; $display("FAIL drain_count: got %0d expected 1", SpikeCount); end
    checks++; if (FIFO_IsQueueEmpty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", FIFO_IsQueueEmpty); end
    tick;
  endtask

  task automatic test_backpressure;
    int got, d0, bad, done_seen;
    got = 0; bad = 0; done_seen = 0;
    load(36'd5, 11'd9);
    load(36'd6, 11'd10);
    SpikeReady = 1'b0; CurrentBT = 36'd100; Start = 1'b1;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick; Start = 1'b0;
      if (SpikeValid) got = 1;
    end
    checks++; if (got !== 1) begin errors++; $display("FAIL bp_offer_timeout: got none expected SpikeValid"); end
    d0 = deq_cnt;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (SpikeValid !== 1'b1 || SpikeNID !== 11'd9 || SpikeBT !== 36'd5) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", bad); end
    checks++; if (deq_cnt !== d0) begin errors++; $display("FAIL bp_no_dequeue: got %0d expected %0d", deq_cnt, d0); end
    SpikeReady = 1'b1;
    tick;
    checks++; if (SpikeValid !== 1'b0 || SpikeCount !== 12'd1) begin errors++; $display("FAIL bp_accept: got valid=%0b count=%0d expected 0 1", SpikeValid, SpikeCount); end
    for (int i = 0; i < 30 && done_seen == 0; i++) begin
      tick;
      if (StepDone) done_seen = 1;
    end
    checks++; if (done_seen !== 1 || SpikeCount !== 12'd2) begin errors++; $display("FAIL bp_finish: got done=%0d count=%0d expected 1 2", done_seen, SpikeCount); end
    tick;
  endtask

  task automatic test_start_wins;
    int e0, done_seen;
    done_seen = 0;
    e0 = enq_cnt;
    ExtBT = 36'd77; ExtNID = 11'd5; ExtValid = 1'b1; CurrentBT = '0; Start = 1'b1;
    #1;
    checks++; if (ExtReady !== 1'b0 || FIFO_Enqueue !== 1'b0) begin errors++; $display("FAIL start_wins_strobe: got rdy=%0b enq=%0b expected 0 0", ExtReady, FIFO_Enqueue); end
    tick; Start = 1'b0; ExtValid = 1'b0;
    checks++; if (Busy !== 1'b1 || enq_cnt !== e0) begin errors++; $display("FAIL start_wins_step: got busy=%0b enq=%0d expected 1 %0d", Busy, enq_cnt, e0); end
    for (int i = 0; i < 10 && done_seen == 0; i++) begin
      tick;
      if (StepDone) done_seen = 1;
    end
    checks++; if (done_seen !== 1) begin errors++; $display("FAIL start_wins_done: got none expected StepDone"); end
    tick;
  endtask

  task automatic test_full;
    int e0, got;
    got = 0;
    e0 = enq_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      ExtBT = BTW'(i * 16); ExtNID = NW'(i); ExtValid = 1'b1;
      tick;
    end
    ExtBT = 36'd99999; ExtNID = 11'd99;
    #1;
    checks++; if (enq_cnt - e0 !== DEPTH) begin errors++; $display("FAIL full_fill_count: got %0d expected %0d", enq_cnt - e0, DEPTH); end
    checks++; if (FIFO_IsQueueFull !== 1'b1 || ExtReady !== 1'b0 || FIFO_Enqueue !== 1'b0)
      begin errors++; $display("FAIL full_extready: got full=%0b rdy=%0b enq=%0b expected 1 0 0", FIFO_IsQueueFull, ExtReady, FIFO_Enqueue); end
    tick;
    checks++; if (enq_cnt - e0 !== DEPTH) begin errors++; $display("FAIL full_no_overflow: got %0d expected %0d", enq_cnt - e0, DEPTH); end
    SpikeReady = 1'b0; CurrentBT = '0; Start = 1'b1;
    #1;
    checks++; if (ExtReady !== 1'b0) begin errors++; $display("FAIL full_start_extready: got %0b expected 0", ExtReady); end
    tick; Start = 1'b0; ExtValid = 1'b0;
    checks++; if (Busy !== 1'b1 || enq_cnt - e0 !== DEPTH) begin errors++; $display("FAIL full_step_begins: got busy=%0b enq=%0d expected 1 %0d", Busy, enq_cnt - e0, DEPTH); end
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick;
      if (SpikeValid) got = 1;
    end
    checks++; if (got !== 1 || SpikeNID !== 11'd0 || SpikeBT !== 36'd0) begin errors++; $display("FAIL full_first_spike: got valid=%0d nid=%0d bt=%0d expected 1 0 0", got, SpikeNID, SpikeBT); end
  endtask

  task automatic test_reset_mid_step;
    int dn0;
    dn0 = done_cnt;
    tick;
    Reset = 1'b1;
    tick;
    checks++; if (SpikeValid !== 1'b0 || Busy !== 1'b1 || StepDone !== 1'b0)
      begin errors++; $display("FAIL midreset_settle: got valid=%0b busy=%0b done=%0b expected 0 1 0", SpikeValid, Busy, StepDone); end
    checks++; if (ExtReady !== 1'b0) begin errors++; $display("FAIL midreset_extready_settle: got %0b expected 0", ExtReady); end
    Reset = 1'b0;
    tick;
    checks++; if (Busy !== 1'b0 || ExtReady !== 1'b1) begin errors++; $display("FAIL midreset_idle: got busy=%0b rdy=%0b expected 0 1", Busy, ExtReady); end
    checks++; if (SpikeCount !== 12'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", SpikeCount); end
    load(36'd1, 11'd1);
    #1;
    checks++; if (ExtReady !== 1'b0) begin errors++; $display("FAIL midreset_refull: got %0b expected 0", ExtReady); end
    tick; tick;
    checks++; if (done_cnt !== dn0) begin errors++; $display("FAIL midreset_no_done: got %0d expected %0d", done_cnt, dn0); end
  endtask

  task automatic test_arbitration;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL arb_enq_deq_overlap: got %0d expected 0", both_cnt); end
    checks++; if (qe_bad !== 0) begin errors++; $display("FAIL arb_queue_enable: got %0d expected 0", qe_bad); end
  endtask

  initial begin
    test_reset();
    test_empty_step();
    test_dispatch();
    test_drain();
    test_backpressure();
    test_start_wins();
    test_full();
    test_reset_mid_step();
    test_arbitration();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
